// File: rtl/sliced_addsub32.sv
// -----------------------------------------------------------------------------
// sliced_addsub32
//
// Multi-cycle 32-bit adder/subtractor. The operands are added SLICE bits per
// clock, least-significant slice first, behind a start/done handshake. The
// result, carry out of bit 31, signed overflow and the derived signed
// less-than flag are loaded into the output registers together on the edge
// that completes the last slice, and are held until the next operation
// completes.
//
// Ports
//   clk_i       : clock, all state updates on the rising edge
//   reset_i     : asynchronous active-high reset, clears state and outputs
//   start_i     : operation request, accepted when not busy
//   op_sub_i    : 1 = a - b, 0 = a + b (sampled with start)
//   a_i, b_i    : 32-bit operands (sampled with start)
//   busy_o      : operation in progress
//   done_o      : one-cycle pulse, results valid
//   sum_o       : a+b or a-b modulo 2^32
//   carryout_o  : carry out of bit 31 (subtract: 1 = no borrow)
//   overflow_o  : carry into bit 31 XOR carry out of bit 31
//   less_o      : sum[31] XOR overflow
// -----------------------------------------------------------------------------
module sliced_addsub32 #(
    parameter int SLICE = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        op_sub_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] sum_o,
    output logic        carryout_o,
    output logic        overflow_o,
    output logic        less_o
);

    localparam int N = 32 / SLICE;

    // Encoding chosen so busy and done are single flop bits.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [5:0]  K_LAST     = 6'(N - 1);
    localparam logic [31:0] SLICE_MASK = 32'((64'd1 << SLICE) - 64'd1);

    logic [1:0]  state_q, state_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic        carry_q, carry_d;
    logic [5:0]  k_q, k_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] sum_q, sum_d;
    logic        cout_q, cout_d;
    logic        ovf_q, ovf_d;
    logic        less_q, less_d;

    logic [4:0]       shamt_s;
    logic [31:0]      opa_sh_s;
    logic [31:0]      opb_sh_s;
    logic [SLICE-1:0] slice_a_s;
    logic [SLICE-1:0] slice_b_s;
    logic [SLICE:0]   slice_res_s;
    logic [31:0]      acc_next_s;
    logic             c31_s;
    logic             ovf_s;

    // Slice datapath: add slice k of both operands plus the running carry.
    always_comb begin
        shamt_s     = 5'(32'(k_q) * 32'(SLICE));
        opa_sh_s    = opa_q >> shamt_s;
        opb_sh_s    = opb_q >> shamt_s;
        slice_a_s   = opa_sh_s[SLICE-1:0];
        slice_b_s   = opb_sh_s[SLICE-1:0];
        slice_res_s = {1'b0, slice_a_s} + {1'b0, slice_b_s} + {{SLICE{1'b0}}, carry_q};
        acc_next_s  = (acc_q & ~(SLICE_MASK << shamt_s))
                    | (32'(slice_res_s[SLICE-1:0]) << shamt_s);
        // Carry into bit 31 recovered from the sum bit: s = a ^ b ^ cin.
        // Only meaningful while the last slice (which holds bit 31) is added.
        c31_s       = opa_q[31] ^ opb_q[31] ^ acc_next_s[31];
        ovf_s       = c31_s ^ slice_res_s[SLICE];
    end

    // Next-state logic for the sequencer and result registers.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        k_d     = k_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        less_d  = less_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    // Subtract is a + ~b + 1, the +1 enters as initial carry.
                    opa_d   = a_i;
                    opb_d   = op_sub_i ? ~b_i : b_i;
                    carry_d = op_sub_i;
                    k_d     = 6'd0;
                    acc_d   = 32'd0;
                    state_d = ST_RUN;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d   = acc_next_s;
                carry_d = slice_res_s[SLICE];
                if (k_q == K_LAST) begin
                    k_d     = 6'd0;
                    state_d = ST_DONE;
                    sum_d   = acc_next_s;
                    cout_d  = slice_res_s[SLICE];
                    ovf_d   = ovf_s;
                    less_d  = acc_next_s[31] ^ ovf_s;
                end else begin
                    k_d     = k_q + 6'd1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                k_d     = 6'd0;
            end
        endcase
    end

    // State and result registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            carry_q <= 1'b0;
            k_q     <= 6'd0;
            acc_q   <= 32'd0;
            sum_q   <= 32'd0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            less_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            less_q  <= less_d;
        end
    end

    assign busy_o     = state_q[0];
    assign done_o     = state_q[1];
    assign sum_o      = sum_q;
    assign carryout_o = cout_q;
    assign overflow_o = ovf_q;
    assign less_o     = less_q;

endmodule
